// File: rtl/rx_pkt_pkg.sv
// Shared constants, packet-type codes and FSM state type for the receive packet parser.
package rx_pkt_pkg;

  localparam int unsigned WORD_WIDTH = 16;
  localparam int unsigned TYPE_W     = 3;

  localparam logic [TYPE_W-1:0] PT_HB    = 3'b001;
  localparam logic [TYPE_W-1:0] PT_CHANN = 3'b010;
  localparam logic [TYPE_W-1:0] PT_MEMB  = 3'b011;
  localparam logic [TYPE_W-1:0] PT_INV   = 3'b100;
  localparam logic [TYPE_W-1:0] PT_DATA  = 3'b101;

  localparam int unsigned W_HDR    = 0;
  localparam int unsigned W_SRC    = 1;
  localparam int unsigned W_HOPS   = 2;
  localparam int unsigned W_CLUS   = 3;
  localparam int unsigned W_ENERGY = 4;
  localparam int unsigned W_QVAL   = 5;
  localparam int unsigned W_KNOWN  = 6;

  typedef enum logic [2:0] {IDLE, COLLECT, CHECK, DROP, FIRE, WAIT_DONE} state_e;

  function automatic logic type_legal(input logic [TYPE_W-1:0] t);
    return t inside {PT_HB, PT_CHANN, PT_MEMB, PT_INV, PT_DATA};
  endfunction

endpackage

// File: rtl/gap_timer.sv
// Idle-cycle counter; pulses tc_o on the enabled cycle that would reach GAP_TIMEOUT.
module gap_timer #(
  parameter int unsigned GAP_TIMEOUT = 64
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic en_i,
  input  logic clr_i,
  output logic tc_o
);

  localparam int unsigned CntW = $clog2(GAP_TIMEOUT + 1);

  logic [CntW-1:0] cnt_q;

  assign tc_o = en_i && !clr_i && (cnt_q == CntW'(GAP_TIMEOUT - 1));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else if (clr_i) begin
      cnt_q <= '0;
    end else if (en_i) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/rx_packet_parser.sv
// Receive-side packet parser: stages a fixed-length word stream, filters self/illegal packets
// and hands accepted fields to the Q-table update stage with a one-cycle start pulse.
module rx_packet_parser #(
  parameter int unsigned WORD_WIDTH  = 16,
  parameter int unsigned PKT_WORDS   = 7,
  parameter int unsigned GAP_TIMEOUT = 64
) (
  input  logic                  clk,
  input  logic                  nrst,
  input  logic [WORD_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [WORD_WIDTH-1:0] myNodeID,
  input  logic                  done,
  output logic                  qtu_en,
  output logic [WORD_WIDTH-1:0] fSourceID,
  output logic [WORD_WIDTH-1:0] fSourceHops,
  output logic [WORD_WIDTH-1:0] fClusterID,
  output logic [WORD_WIDTH-1:0] fEnergyLeft,
  output logic [WORD_WIDTH-1:0] fQValue,
  output logic [WORD_WIDTH-1:0] fKnownCH,
  output logic [2:0]            fPacketType,
  output logic                  dropped,
  output logic                  timeout_err,
  output logic [15:0]           drop_count
);

  import rx_pkt_pkg::*;

  localparam int unsigned IdxW = $clog2(PKT_WORDS);

  state_e                state_q;
  logic [TYPE_W-1:0]     type_q;
  logic [IdxW-1:0]       idx_q;
  logic [WORD_WIDTH-1:0] stage_q [PKT_WORDS];
  logic [WORD_WIDTH-1:0] src_q, hops_q, clus_q, energy_q, qval_q, known_q;
  logic [TYPE_W-1:0]     ptype_q;
  logic                  qtu_en_q, dropped_q, timeout_q;
  logic [15:0]           drop_cnt_q;

  logic        accept;
  logic        gap_tc;
  logic        drop_pkt;
  logic [15:0] drop_cnt_inc;

  assign in_ready     = (state_q == IDLE) || (state_q == COLLECT);
  assign accept       = in_valid && in_ready;
  assign drop_pkt     = !type_legal(type_q) || (stage_q[W_SRC] == myNodeID);
  assign drop_cnt_inc = (drop_cnt_q == 16'hFFFF) ? drop_cnt_q : drop_cnt_q + 16'd1;

  gap_timer #(
    .GAP_TIMEOUT(GAP_TIMEOUT)
  ) u_gap_timer (
    .clk_i (clk),
    .rst_ni(nrst),
    .en_i  ((state_q == COLLECT) && !accept),
    .clr_i ((state_q != COLLECT) || accept),
    .tc_o  (gap_tc)
  );

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q    <= IDLE;
      type_q     <= '0;
      idx_q      <= '0;
      for (int i = 0; i < int'(PKT_WORDS); i++) stage_q[i] <= '0;
      src_q      <= '0;
      hops_q     <= '0;
      clus_q     <= '0;
      energy_q   <= '0;
      qval_q     <= '0;
      known_q    <= '0;
      ptype_q    <= '0;
      qtu_en_q   <= 1'b0;
      dropped_q  <= 1'b0;
      timeout_q  <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      qtu_en_q  <= 1'b0;
      dropped_q <= 1'b0;
      timeout_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (accept) begin
            stage_q[W_HDR] <= in_data;
            type_q         <= in_data[WORD_WIDTH-1 -: TYPE_W];
            idx_q          <= IdxW'(1);
            state_q        <= COLLECT;
          end
        end
        COLLECT: begin
          if (accept) begin
            stage_q[idx_q] <= in_data;
            idx_q          <= idx_q + 1'b1;
            if (idx_q == IdxW'(PKT_WORDS - 1)) state_q <= CHECK;
          end else if (gap_tc) begin
            state_q    <= IDLE;
            timeout_q  <= 1'b1;
            drop_cnt_q <= drop_cnt_inc;
          end
        end
        // Pulses are registered on entry so they coincide with the DROP/FIRE cycle.
        CHECK: begin
          if (drop_pkt) begin
            state_q    <= DROP;
            dropped_q  <= 1'b1;
            drop_cnt_q <= drop_cnt_inc;
          end else begin
            state_q  <= FIRE;
            qtu_en_q <= 1'b1;
            src_q    <= stage_q[W_SRC];
            hops_q   <= stage_q[W_HOPS];
            clus_q   <= stage_q[W_CLUS];
            energy_q <= stage_q[W_ENERGY];
            qval_q   <= stage_q[W_QVAL];
            known_q  <= stage_q[W_KNOWN];
            ptype_q  <= type_q;
          end
        end
        DROP:      state_q <= IDLE;
        FIRE:      state_q <= WAIT_DONE;
        WAIT_DONE: if (done) state_q <= IDLE;
        default:   state_q <= IDLE;
      endcase
    end
  end

  assign qtu_en      = qtu_en_q;
  assign dropped     = dropped_q;
  assign timeout_err = timeout_q;
  assign drop_count  = drop_cnt_q;
  assign fSourceID   = src_q;
  assign fSourceHops = hops_q;
  assign fClusterID  = clus_q;
  assign fEnergyLeft = energy_q;
  assign fQValue     = qval_q;
  assign fKnownCH    = known_q;
  assign fPacketType = ptype_q;

endmodule

// File: tb/tb_rx_packet_parser.sv
// Directed self-checking bench for rx_packet_parser: nominal, back-pressure, filters, gap
// timeout and asynchronous reset in the middle of a packet.
module tb_rx_packet_parser;

  logic        clk = 1'b0;
  logic        nrst = 1'b0;
  logic [15:0] in_data = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] myNodeID = 16'd5;
  logic        done = 1'b0;
  logic        qtu_en;
  logic [15:0] fSourceID, fSourceHops, fClusterID, fEnergyLeft, fQValue, fKnownCH;
  logic [2:0]  fPacketType;
  logic        dropped, timeout_err;
  logic [15:0] drop_count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  rx_packet_parser dut (
    .clk        (clk),
    .nrst       (nrst),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .myNodeID   (myNodeID),
    .done       (done),
    .qtu_en     (qtu_en),
    .fSourceID  (fSourceID),
    .fSourceHops(fSourceHops),
    .fClusterID (fClusterID),
    .fEnergyLeft(fEnergyLeft),
    .fQValue    (fQValue),
    .fKnownCH   (fKnownCH),
    .fPacketType(fPacketType),
    .dropped    (dropped),
    .timeout_err(timeout_err),
    .drop_count (drop_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Inputs change 1ns after a rising edge; the word transfers on the next edge with in_ready.
  task automatic send_word(input logic [15:0] w);
    int n;
    n = 0;
    in_data  = w;
    in_valid = 1'b1;
    while (!in_ready && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (!in_ready) chk("send_ready_bound", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic send_pkt(input logic [15:0] hdr, input logic [15:0] src, input logic [15:0] hops,
                          input logic [15:0] clus, input logic [15:0] en, input logic [15:0] q,
                          input logic [15:0] kch);
    send_word(hdr);
    send_word(src);
    send_word(hops);
    send_word(clus);
    send_word(en);
    send_word(q);
    send_word(kch);
  endtask

  // Called 1ns after the last accept edge.
  task automatic expect_fire(input string tag, input logic [2:0] typ, input logic [15:0] src,
                             input logic [15:0] hops, input logic [15:0] clus,
                             input logic [15:0] en, input logic [15:0] q,
                             input logic [15:0] kch);
    chk({tag, "_check_no_qtu"}, 32'(qtu_en), 32'd0);
    chk({tag, "_check_ready"}, 32'(in_ready), 32'd0);
    @(posedge clk); #1;
    chk({tag, "_qtu_en"}, 32'(qtu_en), 32'd1);
    chk({tag, "_type"}, 32'(fPacketType), 32'(typ));
    chk({tag, "_src"}, 32'(fSourceID), 32'(src));
    chk({tag, "_hops"}, 32'(fSourceHops), 32'(hops));
    chk({tag, "_clus"}, 32'(fClusterID), 32'(clus));
    chk({tag, "_energy"}, 32'(fEnergyLeft), 32'(en));
    chk({tag, "_qval"}, 32'(fQValue), 32'(q));
    chk({tag, "_known"}, 32'(fKnownCH), 32'(kch));
  endtask

  // Called in the FIRE cycle; done is first sampled in WAIT_DONE, so ready returns 2 edges on.
  task automatic release_done(input string tag);
    int n;
    n = 0;
    done = 1'b1;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!in_ready && n < 50);
    done = 1'b0;
    chk({tag, "_done_latency"}, 32'(n), 32'd2);
    chk({tag, "_qtu_single"}, 32'(qtu_en), 32'd0);
  endtask

  task automatic expect_drop(input string tag, input logic [15:0] cnt, input logic [15:0] prev);
    chk({tag, "_check_no_drop"}, 32'(dropped), 32'd0);
    @(posedge clk); #1;
    chk({tag, "_dropped"}, 32'(dropped), 32'd1);
    chk({tag, "_no_qtu"}, 32'(qtu_en), 32'd0);
    chk({tag, "_count"}, 32'(drop_count), 32'(cnt));
    chk({tag, "_fields_held"}, 32'(fSourceID), 32'(prev));
    chk({tag, "_ready_low"}, 32'(in_ready), 32'd0);
    @(posedge clk); #1;
    chk({tag, "_ready_back"}, 32'(in_ready), 32'd1);
    chk({tag, "_drop_single"}, 32'(dropped), 32'd0);
  endtask

  initial begin
    int busy;
    int n;

    // Reset values
    #3;
    chk("rst_ready", 32'(in_ready), 32'd1);
    chk("rst_qtu", 32'(qtu_en), 32'd0);
    chk("rst_dropped", 32'(dropped), 32'd0);
    chk("rst_timeout", 32'(timeout_err), 32'd0);
    chk("rst_src", 32'(fSourceID), 32'd0);
    chk("rst_type", 32'(fPacketType), 32'd0);
    chk("rst_count", 32'(drop_count), 32'd0);
    #7 nrst = 1'b1;
    @(posedge clk); #1;

    // Nominal data packet
    send_pkt(16'hA000, 16'd1, 16'd2, 16'd2, 16'h8000, 16'h3000, 16'd15);
    expect_fire("nom", 3'b101, 16'd1, 16'd2, 16'd2, 16'h8000, 16'h3000, 16'd15);
    @(posedge clk); #1;
    chk("nom_wait_ready", 32'(in_ready), 32'd0);

    // Back-pressure: header held for 20 cycles while done stays low
    in_data  = 16'hA000;
    in_valid = 1'b1;
    busy = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (in_ready) busy++;
    end
    chk("bp_ready_low_cycles", 32'(busy), 32'd0);
    done = 1'b1;
    @(posedge clk); #1;
    done = 1'b0;
    chk("bp_ready_after_done", 32'(in_ready), 32'd1);
    send_pkt(16'hA000, 16'd17, 16'd3, 16'd4, 16'h1800, 16'hB800, 16'd9);
    expect_fire("bp2", 3'b101, 16'd17, 16'd3, 16'd4, 16'h1800, 16'hB800, 16'd9);
    release_done("bp2");

    // Self-packet and illegal-type filters
    send_pkt(16'hA000, 16'd5, 16'd1, 16'd1, 16'd1, 16'd1, 16'd1);
    expect_drop("self", 16'd1, 16'd17);
    send_pkt(16'hE000, 16'd7, 16'd1, 16'd1, 16'd1, 16'd1, 16'd1);
    expect_drop("type111", 16'd2, 16'd17);
    send_pkt(16'h1FFF, 16'd7, 16'd1, 16'd1, 16'd1, 16'd1, 16'd1);
    expect_drop("type000", 16'd3, 16'd17);
    send_pkt(16'hC000, 16'd7, 16'd1, 16'd1, 16'd1, 16'd1, 16'd1);
    expect_drop("type110", 16'd4, 16'd17);

    // Lowest legal type, low header bits ignored
    send_pkt(16'h3FFF, 16'd6, 16'd7, 16'd8, 16'h0001, 16'hFFFF, 16'd0);
    expect_fire("hb", 3'b001, 16'd6, 16'd7, 16'd8, 16'h0001, 16'hFFFF, 16'd0);
    release_done("hb");

    // Gap timeout after 3 words
    send_word(16'h4000);
    send_word(16'd8);
    send_word(16'd1);
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!timeout_err && n < 80);
    chk("gap_cycles", 32'(n), 32'd64);
    chk("gap_ready", 32'(in_ready), 32'd1);
    chk("gap_count", 32'(drop_count), 32'd5);
    chk("gap_fields_held", 32'(fSourceID), 32'd6);
    @(posedge clk); #1;
    chk("gap_single", 32'(timeout_err), 32'd0);
    send_pkt(16'h8000, 16'd9, 16'd2, 16'd3, 16'h0400, 16'h0200, 16'd1);
    expect_fire("post_gap", 3'b100, 16'd9, 16'd2, 16'd3, 16'h0400, 16'h0200, 16'd1);
    release_done("post_gap");

    // Asynchronous reset mid-packet, between edges
    send_word(16'hA000);
    send_word(16'd11);
    send_word(16'd12);
    send_word(16'd13);
    send_word(16'd14);
    #2 nrst = 1'b0;
    #1;
    chk("arst_ready", 32'(in_ready), 32'd1);
    chk("arst_src", 32'(fSourceID), 32'd0);
    chk("arst_known", 32'(fKnownCH), 32'd0);
    chk("arst_count", 32'(drop_count), 32'd0);
    #1 nrst = 1'b1;
    @(posedge clk); #1;
    send_pkt(16'h6000, 16'd21, 16'd4, 16'd5, 16'h0F00, 16'h0A00, 16'd3);
    expect_fire("post_rst", 3'b011, 16'd21, 16'd4, 16'd5, 16'h0F00, 16'h0A00, 16'd3);
    release_done("post_rst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
